// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock transmit FIFO with combinational head read and a dropped-write pulse.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overrun_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign overrun_o = overrun_q;
  assign dout_o    = mem_q[rd_ptr_q];

  // A push against a full FIFO is dropped even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_i && full_o;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter: start, 8 data bits LSB first, stop; txd is registered.
// Build option UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
//
// state   | meaning
// IDLE    | line high, waiting for a queued byte
// START   | start bit (low)
// DATA    | data bits 0..7, LSB first
// PARITY  | even parity of the byte (parity builds only)
// STOP    | stop bit (high); chains straight into the next START if a byte is queued
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overrun,
  output logic       txd
);

  state_e              state_q, state_d;
  logic [15:0]         baud_cnt_q, baud_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                bit_done;
  logic                fifo_pop;
  logic [DATA_W-1:0]   fifo_dout;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (wr),
    .din_i     (din),
    .pop_i     (fifo_pop),
    .dout_o    (fifo_dout),
    .full_o    (full),
    .empty_o   (empty),
    .overrun_o (overrun)
  );

  assign bit_done = (baud_cnt_q == 16'(DIVISOR - 1));
  assign busy     = (state_q != ST_IDLE);
  assign txd      = txd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= STOP_BIT;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from the byte as it leaves the FIFO, before any shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (fifo_pop) begin
      parity_q <= ^fifo_dout;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = '0;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    if (state_q != ST_IDLE && !bit_done) begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (!empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so txd changes on the same edge as the FSM.
  always_comb begin
    txd_d = STOP_BIT;
    case (state_d)
      ST_START:  txd_d = START_BIT;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      default:   txd_d = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes txd and compares.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DIV      = 4;
  localparam int DEPTH    = 4;
  localparam int SLOW_DIV = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = DIV * NBITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0;
  logic       full, empty, busy, overrun, txd;

  logic       reset_s = 1'b1;
  logic [7:0] din_s = 8'h00;
  logic       wr_s = 1'b0;
  logic       full_s, empty_s, busy_s, overrun_s, txd_s;

  always #10 clk = ~clk;

  uart_tx #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .wr      (wr),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .overrun (overrun),
    .txd     (txd)
  );

  uart_tx #(.DIVISOR(SLOW_DIV), .FIFO_DEPTH(DEPTH)) u_slow (
    .clk     (clk),
    .reset   (reset_s),
    .din     (din_s),
    .wr      (wr_s),
    .full    (full_s),
    .empty   (empty_s),
    .busy    (busy_s),
    .overrun (overrun_s),
    .txd     (txd_s)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb_q[$];
  logic       par_q[$];
  int         frames_rx = 0;
  int         ovr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, (busy === 1'b0) ? 32'd0 : 32'd1, 32'd0);
  endtask

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  // Line monitor: decodes one frame per falling start edge, aborts on reset.
  initial begin : monitor
    logic [NBITS-1:0] bits;
    logic             stable;
    logic             aborted;
    logic [7:0]       data;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txd !== 1'b0) continue;
      aborted = 1'b0;
      stable  = 1'b1;
      bits    = '0;
      for (int b = 0; b < NBITS && !aborted; b++) begin
        for (int c = 0; c < DIV; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (c == 0) bits[b] = txd;
          else if (txd !== bits[b]) stable = 1'b0;
        end
      end
      if (aborted) continue;
      data = bits[8:1];
      frames_rx++;
      chk("bit_stable", stable, 1);
      chk("start_bit", bits[0], 0);
      chk("stop_bit", bits[NBITS-1], 1);
`ifdef UART_TX_PARITY_EN
      par_q.push_back(bits[9]);
      chk("parity_even", bits[9], ^data);
`endif
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got 0x%02h expected no frame", data);
      end else begin
        chk("frame_data", data, sb_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         f0;
    int         o0;
    int         n;
    int         lows;
    logic       prev;
    logic [7:0] vec3[3];
    logic [7:0] vec6[6];
    logic [7:0] vecr[3];

    vec3 = '{8'h00, 8'hFF, 8'h55};
    vec6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
    vecr = '{8'h81, 8'h42, 8'h24};

    repeat (3) tick();
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_slow_txd", txd_s, 1);
    chk("rst_slow_flags", {busy_s, empty_s, full_s, overrun_s}, 4'b0100);
    reset   = 1'b0;
    reset_s = 1'b0;
    tick();

    // single 0xA5: latency and frame length
    din = 8'hA5;
    wr  = 1'b1;
    sb_q.push_back(8'hA5);
    tick();
    wr = 1'b0;
    chk("a5_txd_at_k", txd, 1);
    chk("a5_empty_at_k", empty, 0);
    tick();
    chk("a5_txd_k1", txd, 0);
    chk("a5_busy_k1", busy, 1);
    chk("a5_empty_k1", empty, 1);
    repeat (FRAME_CLKS - 1) tick();
    chk("a5_busy_last", busy, 1);
    chk("a5_txd_stop", txd, 1);
    tick();
    chk("a5_busy_end", busy, 0);
    chk("a5_txd_end", txd, 1);
    chk("a5_frames", frames_rx, 1);
    repeat (3) tick();

    // three back-to-back frames
    f0 = frames_rx;
    for (int i = 0; i < 3; i++) begin
      din = vec3[i];
      wr  = 1'b1;
      sb_q.push_back(vec3[i]);
      tick();
    end
    wr = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 60)  chk("b2b_empty_frame2", empty, 0);
      if (n == 100) chk("b2b_empty_frame3", empty, 1);
    end
    chk("b2b_busy_clks", n, 3 * FRAME_CLKS - 1);
    chk("b2b_frames", frames_rx - f0, 3);
    repeat (3) tick();

    // six writes into a four-deep FIFO
    f0 = frames_rx;
    o0 = ovr_cnt;
    for (int i = 0; i < 6; i++) begin
      din = vec6[i];
      wr  = 1'b1;
      if (i < 5) sb_q.push_back(vec6[i]);
      tick();
      if (i == 4) chk("ovr_full", full, 1);
      if (i == 5) chk("ovr_pulse", overrun, 1);
    end
    wr = 1'b0;
    tick();
    chk("ovr_pulse_end", overrun, 0);
    wait_idle("ovr_idle", 6 * FRAME_CLKS + 20);
    tick();
    chk("ovr_pulse_count", ovr_cnt - o0, 1);
    chk("ovr_frames", frames_rx - f0, 5);
    chk("ovr_sb_drained", sb_q.size(), 0);
    repeat (3) tick();

    // reset during data bit 3 of the first of three queued bytes
    f0 = frames_rx;
    for (int i = 0; i < 3; i++) begin
      din = vecr[i];
      wr  = 1'b1;
      sb_q.push_back(vecr[i]);
      tick();
    end
    wr = 1'b0;
    repeat (15) tick();
    chk("rstmid_bit3_low", txd, 0);
    reset = 1'b1;
    wr    = 1'b1;
    din   = 8'hEE;
    sb_q.delete();
    tick();
    reset = 1'b0;
    wr    = 1'b0;
    chk("rstmid_txd", txd, 1);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_busy", busy, 0);
    lows = 0;
    repeat (3 * FRAME_CLKS) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    chk("rstmid_line_quiet", lows, 0);
    chk("rstmid_frames", frames_rx - f0, 0);

`ifdef UART_TX_PARITY_EN
    // parity of 0x01 and 0x03
    par_q.delete();
    din = 8'h01;
    wr  = 1'b1;
    sb_q.push_back(8'h01);
    tick();
    din = 8'h03;
    sb_q.push_back(8'h03);
    tick();
    wr = 1'b0;
    wait_idle("par_idle", 3 * FRAME_CLKS);
    tick();
    chk("par_count", par_q.size(), 2);
    if (par_q.size() == 2) begin
      chk("par_0x01", par_q[0], 1);
      chk("par_0x03", par_q[1], 0);
    end
`endif

    // bit period at DIVISOR=434, 20 ns clock
    din_s = 8'h55;
    wr_s  = 1'b1;
    tick();
    wr_s = 1'b0;
    n = 0;
    while (txd_s !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("slow_start_seen", txd_s, 0);
    for (int t = 0; t < 9; t++) begin
      prev = txd_s;
      n = 0;
      while (txd_s === prev && n < 1000) begin
        tick();
        n++;
      end
      chk("slow_bit_period_clks", (n >= SLOW_DIV - 1 && n <= SLOW_DIV + 1) ? SLOW_DIV : n, SLOW_DIV);
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DIVISOR, default 434, clocks per bit period (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
REQ-005 din  input  8  byte to transmit.
REQ-006 wr  input  1  write strobe; din is sampled on each rising edge where wr=1.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 empty  output  1  FIFO holds 0 bytes.
REQ-009 busy  output  1  frame in progress (any state other than IDLE).
REQ-010 overrun  output  1  one-cycle pulse when a write is dropped.
REQ-011 txd  output  1  serial line, idle high; pairs with the uart_din receive line.

Function
REQ-012 Frame SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-024), 1 stop bit (1); each bit lasts exactly DIVISOR clocks.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is unreachable when UART_TX_PARITY_EN is undefined.
REQ-014 IDLE->START when FIFO is not empty: pop the head into a shift register in the same cycle; txd=0 from the following cycle.
REQ-015 Latency: wr sampled at edge k into an empty FIFO with FSM in IDLE -> txd falls after edge k+1.
REQ-016 START->DATA, DATA->DATA (bit index 0..7), DATA->PARITY/STOP, and PARITY->STOP SHALL occur when the baud counter reaches DIVISOR-1; the counter then reloads to 0.
REQ-017 STOP end with FIFO not empty: pop and go directly to START, with no idle gap between frames; FIFO empty: go to IDLE.
REQ-018 Write with full=1 SHALL be dropped and overrun SHALL pulse, even if a pop occurs in the same cycle.
REQ-019 Simultaneous write and pop when not full: both SHALL take effect; occupancy is unchanged.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.
REQ-021 txd SHALL be registered (glitch-free) and driven high in IDLE and STOP.

Reset
REQ-022 While reset=1: FSM=IDLE, FIFO cleared, baud counter=0, txd=1, busy=0, empty=1, full=0, overrun=0.
REQ-023 Reset mid-frame SHALL abort the frame: txd=1 after the reset edge, all queued bytes discarded; wr is ignored during reset.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent between DATA and STOP, making the frame 11 bit periods; when undefined, the frame is 10 bit periods and no parity logic is generated.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state typedef, the START_BIT/STOP_BIT constants and the data width (8).
REQ-026 The FIFO SHALL be a separate sub-module, uart_fifo (synchronous, single clock, parameterised depth and width); the FSM and baud counter live in uart_tx.

Verification (DIVISOR=4, FIFO_DEPTH=4 unless stated)
REQ-027 Write 0xA5 once -> txd low after edge k+1; bits 1,0,1,0,0,1,0,1 each held 4 clocks; stop high; busy=0 and txd=1 after 40 clocks (44 with parity).
REQ-028 Write 0x00, 0xFF, 0x55 on consecutive cycles -> three back-to-back frames with no idle clocks between them; empty=1 during the third frame.
REQ-029 Write 6 bytes on consecutive cycles while idle -> full asserts; exactly one overrun pulse; 5 frames sent; the 6th byte is absent from the line.
REQ-030 Assert reset for 1 clock during DATA bit 3 of the first of 3 queued bytes -> txd=1 on the next cycle, empty=1, busy=0; no further frames sent.
REQ-031 With UART_TX_PARITY_EN defined, send 0x01 and 0x03 -> parity bits 1 and 0 respectively.
REQ-032 DIVISOR=434 at 50 MHz, send 0x55 -> measured bit period 8.68 us +/- 1 clock.
